// File: rtl/async_pkg.sv
// Shared definitions for the async operator FIFO family.
//   - op_e        : decoded operator selector used by the datapath
//   - MAX_*_SIZE  : upper limits on operand channels and consumer channels
package async_pkg;

  localparam int MAX_INPUT_SIZE  = 3;
  localparam int MAX_OUTPUT_SIZE = 4;

  typedef enum logic [3:0] {
    OP_REG  = 4'd0,
    OP_IN   = 4'd1,
    OP_OUT  = 4'd2,
    OP_ADDI = 4'd3,
    OP_SUBI = 4'd4,
    OP_MULI = 4'd5,
    OP_ADD  = 4'd6,
    OP_SUB  = 4'd7,
    OP_MUL  = 4'd8,
    OP_BAD  = 4'd15
  } op_e;

endpackage

// File: rtl/async_operator.sv
// Combinational operator block: folds the operand heads into one result.
// Ports:
//   operands_i : INPUT_SIZE operands packed, operand i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   result_o   : operator result truncated to DATA_WIDTH bits
module async_operator
  import async_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  INPUT_SIZE = 2,
  parameter op_e OPC        = OP_ADD,
  parameter int  IMMEDIATE  = 0
) (
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] operands_i,
  output logic [DATA_WIDTH-1:0]            result_o
);
  localparam logic [DATA_WIDTH-1:0] IMM = DATA_WIDTH'(IMMEDIATE);

  logic [DATA_WIDTH-1:0] opnd [INPUT_SIZE];

  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_unpack
    assign opnd[i] = operands_i[DATA_WIDTH*i +: DATA_WIDTH];
  end

  // Multi-operand ops fold left from operand 0, so sub is op0-op1-op2.
  always_comb begin
    result_o = opnd[0];
    case (OPC)
      OP_ADDI: result_o = opnd[0] + IMM;
      OP_SUBI: result_o = opnd[0] - IMM;
      OP_MULI: result_o = opnd[0] * IMM;
      OP_ADD:  for (int i = 1; i < INPUT_SIZE; i++) result_o = result_o + opnd[i];
      OP_SUB:  for (int i = 1; i < INPUT_SIZE; i++) result_o = result_o - opnd[i];
      OP_MUL:  for (int i = 1; i < INPUT_SIZE; i++) result_o = result_o * opnd[i];
      default: result_o = opnd[0];
    endcase
  end

endmodule

// File: rtl/op_fifo.sv
// Single operand FIFO, power-of-two depth.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/occupancy only)
//   push, din   : write din when push=1 (caller guarantees not full)
//   pop         : drop the head entry (caller guarantees not empty)
//   head        : current head entry, meaningful while empty=0
//   count       : occupancy, 0..DEPTH
//   full, empty : occupancy flags
module op_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop  ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is data only; stale contents are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/async_operator_fifo.sv
// Operator node with per-channel operand FIFOs and a multi-consumer output.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_l/ack_l : per-channel upstream request out / acknowledge-with-data in
//   din         : operands, channel i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   req_r/ack_r : per-consumer request in / one-cycle acknowledge out
//   dout        : registered result, stable while any consumer is pending
//   fire_count  : number of results produced (wraps)
//   overflow    : sticky, set when a datum arrives at a full FIFO
module async_operator_fifo
  import async_pkg::*;
#(
  parameter int    DATA_WIDTH  = 32,
  parameter int    INPUT_SIZE  = 2,
  parameter int    OUTPUT_SIZE = 2,
  parameter int    DEPTH       = 4,
  parameter string OP          = "add",
  parameter int    IMMEDIATE   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [31:0]                      fire_count,
  output logic                             overflow
);
  localparam op_e OPC =
    (OP == "reg")  ? OP_REG  : (OP == "in")   ? OP_IN   : (OP == "out")  ? OP_OUT  :
    (OP == "addi") ? OP_ADDI : (OP == "subi") ? OP_SUBI : (OP == "muli") ? OP_MULI :
    (OP == "add")  ? OP_ADD  : (OP == "sub")  ? OP_SUB  : (OP == "mul")  ? OP_MUL  : OP_BAD;
  localparam bit IMM_OP   = (OPC == OP_ADDI) || (OPC == OP_SUBI) || (OPC == OP_MULI);
  localparam bit MULTI_OP = (OPC == OP_ADD) || (OPC == OP_SUB) || (OPC == OP_MUL);
  localparam bit DEPTH_OK = (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0);
  localparam int CW       = $clog2(DEPTH) + 1;

  if (OPC == OP_BAD || INPUT_SIZE < 1 || INPUT_SIZE > MAX_INPUT_SIZE ||
      OUTPUT_SIZE < 1 || OUTPUT_SIZE > MAX_OUTPUT_SIZE ||
      (IMM_OP && INPUT_SIZE != 1) || (MULTI_OP && INPUT_SIZE < 2) || !DEPTH_OK) begin : g_illegal
    $error("async_operator_fifo: illegal OP/INPUT_SIZE/OUTPUT_SIZE/DEPTH combination");
  end

  logic [INPUT_SIZE-1:0]            push, full, empty;
  logic [DATA_WIDTH*INPUT_SIZE-1:0] heads;
  logic [CW-1:0]                    count    [INPUT_SIZE];
  logic [CW-1:0]                    next_occ [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]            result;
  logic                             fire;

  logic [INPUT_SIZE-1:0]  req_l_q, req_l_d;
  logic [OUTPUT_SIZE-1:0] pending_q, pending_d, ack_r_q, ack_r_d, served;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic [31:0]            fire_count_q, fire_count_d;
  logic                   overflow_q, overflow_d;

  // A datum arriving at a full FIFO is dropped rather than pushed.
  assign push = ack_l & ~full;
  // Firing waits for ack_r to drop so dout holds through the cycle after each ack.
  assign fire = (&(~empty)) & ~out_valid_q & ~(|ack_r_q);

  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_fifo
    op_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (fire),
      .din   (din[DATA_WIDTH*i +: DATA_WIDTH]),
      .head  (heads[DATA_WIDTH*i +: DATA_WIDTH]),
      .count (count[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
    // Leaving one slot spare absorbs an ack already in flight when req_l drops.
    assign next_occ[i] = count[i] + CW'(push[i]) - CW'(fire);
    assign req_l_d[i]  = (next_occ[i] <= CW'(DEPTH - 2));
  end

  async_operator #(
    .DATA_WIDTH (DATA_WIDTH),
    .INPUT_SIZE (INPUT_SIZE),
    .OPC        (OPC),
    .IMMEDIATE  (IMMEDIATE)
  ) u_op (
    .operands_i (heads),
    .result_o   (result)
  );

  always_comb begin
    served       = pending_q & req_r & ~ack_r_q;
    ack_r_d      = served;
    pending_d    = pending_q & ~served;
    out_valid_d  = out_valid_q;
    dout_d       = dout_q;
    fire_count_d = fire_count_q;
    overflow_d   = overflow_q | (|(ack_l & full));
    if (out_valid_q && (pending_d == '0)) out_valid_d = 1'b0;
    // fire implies out_valid_q=0, hence pending_q=0: no overlap with serving.
    if (fire) begin
      pending_d    = '1;
      out_valid_d  = 1'b1;
      dout_d       = result;
      fire_count_d = fire_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_l_q      <= '0;
      ack_r_q      <= '0;
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      dout_q       <= '0;
      fire_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      req_l_q      <= req_l_d;
      ack_r_q      <= ack_r_d;
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      dout_q       <= dout_d;
      fire_count_q <= fire_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign req_l      = req_l_q;
  assign ack_r      = ack_r_q;
  assign dout       = dout_q;
  assign fire_count = fire_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_async_operator_fifo.sv
// Directed bench for async_operator_fifo using three configurations:
//   A: add, 32-bit, 2 inputs, 3 consumers, DEPTH 4
//   B: addi IMMEDIATE=2, 8-bit, 1 input, 1 consumer, DEPTH 2
//   C: sub, 16-bit, 3 inputs, 1 consumer, DEPTH 2
module tb_async_operator_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Config A
  logic [1:0]  req_l_a, ack_l_a;
  logic [63:0] din_a;
  logic [2:0]  req_r_a, ack_r_a;
  logic [31:0] dout_a, fc_a;
  logic        ovf_a;
  // Config B
  logic [0:0]  req_l_b, ack_l_b;
  logic [7:0]  din_b, dout_b;
  logic [0:0]  req_r_b, ack_r_b;
  logic [31:0] fc_b;
  logic        ovf_b;
  // Config C
  logic [2:0]  req_l_c, ack_l_c;
  logic [47:0] din_c;
  logic [0:0]  req_r_c, ack_r_c;
  logic [15:0] dout_c;
  logic [31:0] fc_c;
  logic        ovf_c;

  async_operator_fifo #(.DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(3), .DEPTH(4),
                        .OP("add"), .IMMEDIATE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .req_l(req_l_a), .ack_l(ack_l_a), .din(din_a),
    .req_r(req_r_a), .ack_r(ack_r_a), .dout(dout_a), .fire_count(fc_a), .overflow(ovf_a));

  async_operator_fifo #(.DATA_WIDTH(8), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(2),
                        .OP("addi"), .IMMEDIATE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .req_l(req_l_b), .ack_l(ack_l_b), .din(din_b),
    .req_r(req_r_b), .ack_r(ack_r_b), .dout(dout_b), .fire_count(fc_b), .overflow(ovf_b));

  async_operator_fifo #(.DATA_WIDTH(16), .INPUT_SIZE(3), .OUTPUT_SIZE(1), .DEPTH(2),
                        .OP("sub"), .IMMEDIATE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .req_l(req_l_c), .ack_l(ack_l_c), .din(din_c),
    .req_r(req_r_c), .ack_r(ack_r_c), .dout(dout_c), .fire_count(fc_c), .overflow(ovf_c));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur_fc(input int sel);
    case (sel)
      0:       return fc_a;
      1:       return fc_b;
      default: return fc_c;
    endcase
  endfunction

  // Bounded wait for a fire counter to reach target; the caller checks the count.
  task automatic wait_count(input int sel, input logic [31:0] target);
    for (int k = 0; k < 30; k++) begin
      if (cur_fc(sel) == target) break;
      tick();
    end
  endtask

  // Single-cycle producer beat on config A.
  task automatic push_a(input logic [31:0] op0, input logic [31:0] op1);
    din_a   = {op1, op0};
    ack_l_a = 2'b11;
    tick();
    ack_l_a = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    ack_l_a = '0; din_a = '0; req_r_a = '0;
    ack_l_b = '0; din_b = '0; req_r_b = '0;
    ack_l_c = '0; din_c = '0; req_r_c = '0;

    // Reset state
    #2;
    check("rst_req_l_a", req_l_a, 0);
    check("rst_ack_r_a", ack_r_a, 0);
    check("rst_dout_a", dout_a, 0);
    check("rst_fc_a", fc_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("req_l_a_after_release", req_l_a, 2'b11);
    check("req_l_b_after_release", req_l_b, 1'b1);
    check("req_l_c_after_release", req_l_c, 3'b111);

    // A: first result one cycle after operands become heads
    push_a(32'd5, 32'd7);
    check("a_no_early_fire", fc_a, 0);
    tick();
    check("a_first_dout", dout_a, 12);
    check("a_first_fc", fc_a, 1);

    // A: consumers 0/1 served, consumer 2 stalls the node
    req_r_a = 3'b011;
    tick();
    check("a_ack_01", ack_r_a, 3'b011);
    push_a(32'd1, 32'd2);
    check("a_ack_pulse_one_cycle", ack_r_a, 3'b000);
    tick(3);
    check("a_stall_no_fire", fc_a, 1);
    check("a_stall_dout_held", dout_a, 12);
    req_r_a = 3'b100;
    tick();
    check("a_ack_2", ack_r_a, 3'b100);
    check("a_dout_during_ack", dout_a, 12);
    tick();
    check("a_no_fire_during_ack", fc_a, 1);
    check("a_dout_after_ack", dout_a, 12);
    tick();
    check("a_second_fc", fc_a, 2);
    check("a_second_dout", dout_a, 3);
    req_r_a = 3'b111;
    tick();
    check("a_ack_all", ack_r_a, 3'b111);
    tick();

    // A: backpressure and overflow with consumers stalled
    req_r_a = 3'b000;
    push_a(32'd100, 32'd1);
    tick();
    check("a_third_dout", dout_a, 101);
    push_a(32'd4, 32'd4);
    check("a_req_occ1", req_l_a, 2'b11);
    push_a(32'd5, 32'd5);
    check("a_req_occ2", req_l_a, 2'b11);
    push_a(32'd6, 32'd6);
    check("a_req_occ3_drop", req_l_a, 2'b00);
    push_a(32'd7, 32'd7);
    check("a_full_no_ovf", ovf_a, 0);
    push_a(32'd8, 32'd8);
    check("a_ovf_set", ovf_a, 1);
    tick(3);
    check("a_ovf_sticky", ovf_a, 1);

    // A: drain, the dropped datum never appears
    req_r_a = 3'b111;
    wait_count(0, 32'd4);
    check("a_drain1_fc", fc_a, 4);
    check("a_drain1_dout", dout_a, 8);
    wait_count(0, 32'd5);
    check("a_drain2_dout", dout_a, 10);
    wait_count(0, 32'd6);
    check("a_drain3_dout", dout_a, 12);
    wait_count(0, 32'd7);
    check("a_drain4_dout", dout_a, 14);
    tick(10);
    check("a_dropped_not_fired", fc_a, 7);
    check("a_req_after_drain", req_l_a, 2'b11);

    // A: reset mid-stream with operands buffered
    req_r_a = 3'b000;
    push_a(32'd1, 32'd1);
    tick();
    check("a_pre_reset_dout", dout_a, 2);
    push_a(32'd2, 32'd2);
    push_a(32'd3, 32'd3);
    push_a(32'd4, 32'd4);
    rst_n = 1'b0;
    #1;
    check("a_midrst_dout", dout_a, 0);
    check("a_midrst_fc", fc_a, 0);
    check("a_midrst_req_l", req_l_a, 0);
    check("a_midrst_ovf", ovf_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("a_req_after_midrst", req_l_a, 2'b11);
    check("a_no_stale_fire", fc_a, 0);
    req_r_a = 3'b111;
    push_a(32'd3, 32'd4);
    tick();
    check("a_fresh_dout", dout_a, 7);
    check("a_fresh_fc", fc_a, 1);

    // B: addi wraps at 8 bits, DEPTH=2 backpressure and overflow
    din_b = 8'd255; ack_l_b = 1'b1;
    tick();
    ack_l_b = 1'b0;
    check("b_req_drop_occ1", req_l_b, 1'b0);
    tick();
    check("b_addi_wrap", dout_b, 1);
    check("b_fc1", fc_b, 1);
    check("b_req_back", req_l_b, 1'b1);
    din_b = 8'd10; ack_l_b = 1'b1;
    tick();
    check("b_req_drop_again", req_l_b, 1'b0);
    din_b = 8'd20;
    tick();
    check("b_full_no_ovf", ovf_b, 0);
    din_b = 8'd30;
    tick();
    ack_l_b = 1'b0;
    check("b_ovf_set", ovf_b, 1);
    req_r_b = 1'b1;
    wait_count(1, 32'd2);
    check("b_second_dout", dout_b, 12);
    wait_count(1, 32'd3);
    check("b_third_dout", dout_b, 22);
    tick(10);
    check("b_dropped_not_fired", fc_b, 3);
    check("b_ovf_sticky", ovf_b, 1);

    // C: three-operand sub fires only when every head is valid
    req_r_c = 1'b1;
    din_c = {16'd20, 16'd3, 16'd10};
    ack_l_c = 3'b011;
    tick();
    ack_l_c = 3'b000;
    tick(2);
    check("c_partial_no_fire", fc_c, 0);
    ack_l_c = 3'b100;
    tick();
    ack_l_c = 3'b000;
    tick();
    check("c_sub_wrap", dout_c, 16'd65523);
    check("c_fc1", fc_c, 1);
    din_c = {16'd2, 16'd1, 16'd100};
    ack_l_c = 3'b111;
    tick();
    ack_l_c = 3'b000;
    wait_count(2, 32'd2);
    check("c_fc2", fc_c, 2);
    check("c_sub_dout", dout_c, 97);
    check("c_no_ovf", ovf_c, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
